// File: rtl/lsu_unit.sv
// RV32I load/store unit: one request at a time, checked for funct3/alignment/range,
// driven onto a byte-addressed memory, with the load result returned over a response handshake.
module lsu_unit #(
  parameter int MEM_BYTES   = 2048,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [1:0]  mem_write_mode,
  input  logic [31:0] mem_read_data
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] resp_data_q;
  logic [1:0]  resp_err_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wr_data_q;
  logic [1:0]  mem_write_mode_q;

  logic [31:0] eff_addr;
  logic [2:0]  acc_size;
  logic [32:0] acc_end;
  logic [1:0]  fault;
  logic [31:0] store_fmt;
  logic [31:0] load_val;
  logic        accept;

  always_comb begin
    eff_addr = req_base + {{20{req_offset[11]}}, req_offset};
    case (req_funct3[1:0])
      2'd1:    acc_size = 3'd2;
      2'd2:    acc_size = 3'd4;
      default: acc_size = 3'd1;
    endcase
    // Range end computed one bit wider so addresses near 2^32 cannot wrap into range.
    acc_end = {1'b0, eff_addr} + {30'd0, acc_size};
    fault = 2'd0;
    if (req_is_store ? (req_funct3 >= 3'd3)
                     : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11))
      fault = 2'd3;
    else if (CHECK_ALIGN && ((acc_size == 3'd2 && eff_addr[0]) ||
                             (acc_size == 3'd4 && eff_addr[1:0] != 2'b00)))
      fault = 2'd1;
    else if (acc_end > 33'(MEM_BYTES))
      fault = 2'd2;
  end

  // Memory expects the first byte on [31:24].
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    store_fmt = {req_store_data[7:0], 24'd0};
      2'd1:    store_fmt = {req_store_data[15:0], 16'd0};
      default: store_fmt = req_store_data;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'd0:    load_val = {{24{mem_read_data[31]}}, mem_read_data[31:24]};
      3'd4:    load_val = {24'd0, mem_read_data[31:24]};
      3'd1:    load_val = {{16{mem_read_data[31]}}, mem_read_data[31:16]};
      3'd5:    load_val = {16'd0, mem_read_data[31:16]};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_wr_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (fault != 2'd0) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_wr_enable = store_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q         <= 3'd0;
      store_q          <= 1'b0;
      resp_data_q      <= 32'd0;
      resp_err_q       <= 2'd0;
      mem_address_q    <= 32'd0;
      mem_wr_data_q    <= 32'd0;
      mem_write_mode_q <= 2'd0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        store_q  <= req_is_store;
        if (fault != 2'd0) begin
          resp_err_q  <= fault;
          resp_data_q <= 32'd0;
        end else begin
          mem_address_q <= eff_addr;
          if (req_is_store) begin
            mem_wr_data_q    <= store_fmt;
            mem_write_mode_q <= req_funct3[1:0];
          end
        end
      end
      if (state_q == S_ACCESS) begin
        resp_err_q  <= 2'd0;
        resp_data_q <= store_q ? 32'd0 : load_val;
      end
    end
  end

  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign mem_address    = mem_address_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign mem_write_mode = mem_write_mode_q;

endmodule
